// File: rtl/seq_engine_poly.sv
// -----------------------------------------------------------------------------
// seq_engine_poly
//
// Polyphonic song sequencer. It fetches 16-bit instructions from an external
// SRAM, keeps tempo (BPM) and nested repeat state, and times notes. It drives
// NUM_VOICES voice words and gates to the downstream tone generators. Notes
// with the chord flag set load successive voices without starting the timer.
// The first note without the chord flag closes the group and starts timing.
//
// Instruction encoding (bits [15:12]):
//   1xxx NOTE   [14] chord, [13:12] style, [11:8] len, [7:6] vol, [5:4] oct,
//               [3:0] pitch
//   0000 END    halt until reset
//   0001 BPM    tempo = [11:0] (0 is treated as 1)
//   0010 REP_HI upper repeat-target bits = low ADDR_W-6 bits of [11:0]
//   0011 REP    lo=[11:6], cnt=[5:3], lvl=[2:0]
//   01xx NOP
//
// Ports:
//   CLK          in   clock
//   RST_N        in   asynchronous active-low reset
//   PAUSE        in   freezes the FSM and the note timer, and forces gates low
//   MEM_A        out  SRAM address (ADDR_W)
//   MEM_D        in   SRAM read data, valid MEM_LAT cycles after MEM_A changes
//   VOICE_NOTE   out  voice v raw note word at [16v+15:16v]
//   VOICE_GATE   out  voice v sounding
//   NOTE_STROBE  out  1-cycle pulse when a note group starts timing
//   HALTED       out  END reached
//   PC           out  current instruction address
//
// The REP_HI field holds at most 12 bits, so ADDR_W must be in the range 7..18.
// -----------------------------------------------------------------------------
module seq_engine_poly #(
    parameter int ADDR_W      = 18,
    parameter int NUM_VOICES  = 4,
    parameter int REP_DEPTH   = 8,
    parameter int MEM_LAT     = 2,
    parameter int CLK_HZ      = 50000000,
    parameter int DEFAULT_BPM = 96,
    parameter int STACC_CYC   = 10000000,
    parameter int NORM_CYC    = 2000000
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     PAUSE,
    output logic [ADDR_W-1:0]        MEM_A,
    input  logic [15:0]              MEM_D,
    output logic [16*NUM_VOICES-1:0] VOICE_NOTE,
    output logic [NUM_VOICES-1:0]    VOICE_GATE,
    output logic                     NOTE_STROBE,
    output logic                     HALTED,
    output logic [ADDR_W-1:0]        PC
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_DIV   = 3'd3;
    localparam logic [2:0] S_PLAY  = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    localparam int          HI_W        = ADDR_W - 6;
    localparam logic [63:0] CYC_MIN_64  = 64'(CLK_HZ) * 64'd60;
    localparam logic [31:0] CYC_PER_MIN = CYC_MIN_64[31:0];
    localparam logic [31:0] CPB_RESET   = 32'(CYC_MIN_64 / 64'(DEFAULT_BPM));
    localparam logic [31:0] STACC_GAP   = 32'(STACC_CYC);
    localparam logic [31:0] NORM_GAP    = 32'(NORM_CYC);
    localparam logic [7:0]  WAIT_LAST   = 8'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    logic [2:0]        r_state;
    logic [7:0]        r_wait;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_a;
    logic [HI_W-1:0]   r_rep_hi;
    logic [2:0]        r_rep_ctr [8];
    logic [15:0]       r_voice [NUM_VOICES];
    logic [2:0]        r_vi;
    logic [1:0]        r_style;
    logic [31:0]       r_cpb;
    logic [31:0]       r_dur;
    logic [31:0]       r_timer;
    logic              r_strobe;
    logic              r_halted;
    logic [31:0]       r_div_rem;
    logic [31:0]       r_div_quo;
    logic [31:0]       r_div_den;
    logic [4:0]        r_div_cnt;

    logic [3:0]        w_op;
    logic              w_chord;
    logic [2:0]        w_len_sh;
    logic [31:0]       w_dur;
    logic [2:0]        w_lvl;
    logic [2:0]        w_cnt;
    logic [ADDR_W-1:0] w_rep_target;
    logic              w_rep_valid;
    logic [2:0]        w_rep_cur;
    logic [11:0]       w_bpm;
    logic [32:0]       w_rem_shift;
    logic [32:0]       w_rem_diff;
    logic              w_rem_ge;
    logic [31:0]       w_quo_next;
    logic [31:0]       w_gap;
    logic              w_play_on;
    logic              w_play_done;
    logic [NUM_VOICES-1:0] w_gate;

    // Instruction field decode straight off the SRAM data bus; it is only
    // consumed in EXEC, where MEM_D is stable for the addressed word.
    always_comb begin
        w_op         = MEM_D[15:12];
        w_chord      = MEM_D[14];
        w_len_sh     = MEM_D[11] ? 3'd7 : MEM_D[10:8];
        w_dur        = (r_cpb >> 3) << w_len_sh;
        w_lvl        = MEM_D[2:0];
        w_cnt        = MEM_D[5:3];
        w_rep_target = {r_rep_hi, MEM_D[11:6]};
        w_rep_valid  = (int'(w_lvl) < REP_DEPTH) && (w_cnt != 3'd0);
        w_rep_cur    = r_rep_ctr[w_lvl];
        w_bpm        = (MEM_D[11:0] == 12'd0) ? 12'd1 : MEM_D[11:0];
    end

    // One restoring-division step per cycle. The borrow out of the 33-bit
    // subtraction tells whether the shifted remainder covers the divisor.
    always_comb begin
        w_rem_shift = {r_div_rem, r_div_quo[31]};
        w_rem_diff  = w_rem_shift - {1'b0, r_div_den};
        w_rem_ge    = ~w_rem_diff[32];
        w_quo_next  = {r_div_quo[30:0], w_rem_ge};
    end

    // The gate is high during the sounding part of the note: timer < dur - gap.
    // A gap at least as long as the note keeps the gate low for the whole note.
    always_comb begin
        w_gap = 32'd0;
        case (r_style)
            2'd0:    w_gap = r_dur;
            2'd1:    w_gap = STACC_GAP;
            2'd2:    w_gap = NORM_GAP;
            default: w_gap = 32'd0;
        endcase
        w_play_on   = (r_state == S_PLAY) && !PAUSE && (w_gap < r_dur) &&
                      (r_timer < (r_dur - w_gap));
        w_play_done = (r_timer + 32'd1) >= r_dur;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_gate[v] = w_play_on && r_voice[v][15];
        end
    end

    // Main sequencer FSM. PAUSE freezes every piece of state; only the strobe
    // still self-clears so that it stays a single-cycle pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_pc      <= '0;
            r_mem_a   <= '0;
            r_rep_hi  <= '0;
            r_vi      <= '0;
            r_style   <= '0;
            r_cpb     <= CPB_RESET;
            r_dur     <= '0;
            r_timer   <= '0;
            r_strobe  <= 1'b0;
            r_halted  <= 1'b0;
            r_div_rem <= '0;
            r_div_quo <= '0;
            r_div_den <= 32'd1;
            r_div_cnt <= '0;
            for (int i = 0; i < 8; i++) begin
                r_rep_ctr[i] <= '0;
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_voice[v] <= '0;
            end
        end else begin
            r_strobe <= 1'b0;
            if (!PAUSE) begin
                case (r_state)
                    S_FETCH: begin
                        r_mem_a <= r_pc;
                        r_wait  <= '0;
                        r_state <= (MEM_LAT == 0) ? S_EXEC : S_WAIT;
                    end
                    S_WAIT: begin
                        if (r_wait == WAIT_LAST) begin
                            r_state <= S_EXEC;
                        end else begin
                            r_wait <= r_wait + 8'd1;
                        end
                    end
                    S_EXEC: begin
                        if (MEM_D[15]) begin
                            // Chord members load one voice each; the closing
                            // note also wipes any voices above it from older
                            // groups.
                            for (int v = 0; v < NUM_VOICES; v++) begin
                                if (v == int'(r_vi)) begin
                                    r_voice[v] <= MEM_D;
                                end else if (v > int'(r_vi) && !w_chord) begin
                                    r_voice[v] <= '0;
                                end
                            end
                            if (w_chord) begin
                                if (int'(r_vi) < NUM_VOICES - 1) begin
                                    r_vi <= r_vi + 3'd1;
                                end
                                r_pc    <= r_pc + PC_ONE;
                                r_state <= S_FETCH;
                            end else begin
                                r_vi     <= '0;
                                r_style  <= MEM_D[13:12];
                                r_dur    <= w_dur;
                                r_timer  <= '0;
                                r_strobe <= 1'b1;
                                r_state  <= S_PLAY;
                            end
                        end else begin
                            case (w_op)
                                4'b0000: begin
                                    r_halted <= 1'b1;
                                    r_state  <= S_HALT;
                                end
                                4'b0001: begin
                                    r_div_rem <= '0;
                                    r_div_quo <= CYC_PER_MIN;
                                    r_div_den <= {20'd0, w_bpm};
                                    r_div_cnt <= '0;
                                    r_state   <= S_DIV;
                                end
                                4'b0010: begin
                                    r_rep_hi <= MEM_D[HI_W-1:0];
                                    r_pc     <= r_pc + PC_ONE;
                                    r_state  <= S_FETCH;
                                end
                                4'b0011: begin
                                    // Counter 0 arms the loop, 1 is the last
                                    // pass, anything else counts down.
                                    if (!w_rep_valid) begin
                                        r_pc <= r_pc + PC_ONE;
                                    end else if (w_rep_cur == 3'd0) begin
                                        r_rep_ctr[w_lvl] <= w_cnt;
                                        r_pc             <= w_rep_target;
                                    end else if (w_rep_cur == 3'd1) begin
                                        r_rep_ctr[w_lvl] <= 3'd0;
                                        r_pc             <= r_pc + PC_ONE;
                                    end else begin
                                        r_rep_ctr[w_lvl] <= w_rep_cur - 3'd1;
                                        r_pc             <= w_rep_target;
                                    end
                                    r_state <= S_FETCH;
                                end
                                default: begin
                                    r_pc    <= r_pc + PC_ONE;
                                    r_state <= S_FETCH;
                                end
                            endcase
                        end
                    end
                    S_DIV: begin
                        r_div_rem <= w_rem_ge ? w_rem_diff[31:0] : w_rem_shift[31:0];
                        r_div_quo <= w_quo_next;
                        r_div_cnt <= r_div_cnt + 5'd1;
                        if (r_div_cnt == 5'd31) begin
                            r_cpb   <= w_quo_next;
                            r_pc    <= r_pc + PC_ONE;
                            r_state <= S_FETCH;
                        end
                    end
                    S_PLAY: begin
                        if (w_play_done) begin
                            r_pc    <= r_pc + PC_ONE;
                            r_state <= S_FETCH;
                        end else begin
                            r_timer <= r_timer + 32'd1;
                        end
                    end
                    default: begin
                        r_state <= S_HALT;
                    end
                endcase
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice_out
            assign VOICE_NOTE[16*g +: 16] = r_voice[g];
        end
    endgenerate

    assign MEM_A       = r_mem_a;
    assign PC          = r_pc;
    assign VOICE_GATE  = w_gate;
    assign NOTE_STROBE = r_strobe;
    assign HALTED      = r_halted;

endmodule

// File: tb/tb_seq_engine_poly.sv
// -----------------------------------------------------------------------------
// tb_seq_engine_poly
//
// Directed bench for seq_engine_poly. It uses a small clock (960 Hz, 60 BPM),
// so one beat is 960 cycles. Each scenario writes a program into the SRAM
// model and pushes the expected note groups onto a queue. A monitor pops one
// entry per NOTE_STROBE. It compares the voice words and gates at the strobe,
// then the number of gate-high cycles and the total note span, which ends at
// the next strobe or at HALTED.
// -----------------------------------------------------------------------------
module tb_seq_engine_poly;

    localparam int ADDR_W     = 8;
    localparam int NUM_VOICES = 4;
    localparam int MEM_LAT    = 2;

    logic                     CLK   = 1'b0;
    logic                     RST_N = 1'b1;
    logic                     PAUSE = 1'b0;
    logic [ADDR_W-1:0]        MEM_A;
    logic [15:0]              MEM_D;
    logic [16*NUM_VOICES-1:0] VOICE_NOTE;
    logic [NUM_VOICES-1:0]    VOICE_GATE;
    logic                     NOTE_STROBE;
    logic                     HALTED;
    logic [ADDR_W-1:0]        PC;

    logic [15:0]       mem [256];
    logic [ADDR_W-1:0] addrPipe [MEM_LAT];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [63:0] notes;
        logic [3:0]  gates;
        int          high;
        int          span;
    } noteExp_t;

    noteExp_t expQ[$];
    noteExp_t curExp;
    logic     recOpen    = 1'b0;
    logic     prevHalted = 1'b0;
    int       recHigh    = 0;
    int       recSpan    = 0;
    int       latency;

    seq_engine_poly #(
        .ADDR_W      (ADDR_W),
        .NUM_VOICES  (NUM_VOICES),
        .REP_DEPTH   (4),
        .MEM_LAT     (MEM_LAT),
        .CLK_HZ      (960),
        .DEFAULT_BPM (60),
        .STACC_CYC   (2000),
        .NORM_CYC    (100)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .PAUSE       (PAUSE),
        .MEM_A       (MEM_A),
        .MEM_D       (MEM_D),
        .VOICE_NOTE  (VOICE_NOTE),
        .VOICE_GATE  (VOICE_GATE),
        .NOTE_STROBE (NOTE_STROBE),
        .HALTED      (HALTED),
        .PC          (PC)
    );

    always #5 CLK = ~CLK;

    // SRAM model: the read data follows the address after MEM_LAT clock edges.
    always @(posedge CLK) begin
        addrPipe[0] <= MEM_A;
        for (int i = 1; i < MEM_LAT; i++) begin
            addrPipe[i] <= addrPipe[i-1];
        end
    end

    assign MEM_D = mem[addrPipe[MEM_LAT-1]];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic expectNote(input int id, input logic [63:0] notes,
                              input logic [3:0] gates, input int high, input int span);
        noteExp_t e;
        e.id    = id;
        e.notes = notes;
        e.gates = gates;
        e.high  = high;
        e.span  = span;
        expQ.push_back(e);
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0000;
        end
    endtask

    // Pulse the reset and release it just after a falling edge.
    task automatic applyStimulus();
        @(negedge CLK);
        #1 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        #1 RST_N = 1'b1;
    endtask

    task automatic waitStrobe(input int budget, output int n);
        n = 0;
        while (NOTE_STROBE !== 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic waitHalted(input string tag, input int budget);
        int n;
        n = 0;
        while (HALTED !== 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checkOutput({tag, "_halted"}, 64'(HALTED), 64'd1);
    endtask

    task automatic finishScenario(input string tag, input logic [ADDR_W-1:0] expPc);
        repeat (3) @(negedge CLK);
        checkOutput({tag, "_PC"}, 64'(PC), 64'(expPc));
        checkOutput({tag, "_gatesIdle"}, 64'(VOICE_GATE), 64'd0);
        checkOutput({tag, "_queueDrained"}, 64'(expQ.size()), 64'd0);
    endtask

    task automatic closeRecord();
        checkOutput($sformatf("note%0d_gateHigh", curExp.id), 64'(recHigh), 64'(curExp.high));
        checkOutput($sformatf("note%0d_span", curExp.id), 64'(recSpan), 64'(curExp.span));
        recOpen = 1'b0;
    endtask

    // Monitor: one record per note group, opened on the strobe and closed on
    // the next strobe or when HALTED rises. A reset discards the open record.
    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (RST_N !== 1'b1) begin
                recOpen    = 1'b0;
                prevHalted = 1'b0;
            end else begin
                if (NOTE_STROBE === 1'b1) begin
                    if (recOpen) closeRecord();
                    checkOutput("noteQueueNonEmpty", 64'(expQ.size() > 0), 64'd1);
                    if (expQ.size() > 0) begin
                        curExp = expQ.pop_front();
                        checkOutput($sformatf("note%0d_voices", curExp.id), VOICE_NOTE, curExp.notes);
                        checkOutput($sformatf("note%0d_gatesAtStrobe", curExp.id), 64'(VOICE_GATE), 64'(curExp.gates));
                        recOpen = 1'b1;
                        recHigh = (VOICE_GATE[0] === 1'b1) ? 1 : 0;
                        recSpan = 1;
                    end
                end else if (HALTED === 1'b1 && !prevHalted) begin
                    if (recOpen) closeRecord();
                end else if (recOpen) begin
                    recSpan++;
                    if (VOICE_GATE[0] === 1'b1) recHigh++;
                end
                prevHalted = (HALTED === 1'b1);
            end
        end
    end

    initial begin
        clearMem();

        // Reset values, observed while reset is asserted and before any clock edge.
        #1 RST_N = 1'b0;
        #2;
        checkOutput("reset_PC", 64'(PC), 64'd0);
        checkOutput("reset_MEM_A", 64'(MEM_A), 64'd0);
        checkOutput("reset_VOICE_NOTE", VOICE_NOTE, 64'd0);
        checkOutput("reset_VOICE_GATE", 64'(VOICE_GATE), 64'd0);
        checkOutput("reset_NOTE_STROBE", 64'(NOTE_STROBE), 64'd0);
        checkOutput("reset_HALTED", 64'(HALTED), 64'd0);

        // Single one-beat legato note, then END.
        $display("[TB] scenario s1: single note");
        clearMem();
        mem[0] = 16'hB31A;
        mem[1] = 16'h0000;
        expectNote(1, 64'h0000_0000_0000_B31A, 4'b0001, 960, 964);
        applyStimulus();
        waitStrobe(200, latency);
        checkOutput("s1_strobeLatency", 64'(latency), 64'd4);
        waitHalted("s1", 3000);
        finishScenario("s1", 8'd1);

        // BPM 120: 32-cycle divide, then a one-beat note of 480 cycles.
        $display("[TB] scenario s2: tempo change");
        clearMem();
        mem[0] = 16'h1078;
        mem[1] = 16'hB31A;
        mem[2] = 16'h0000;
        expectNote(2, 64'h0000_0000_0000_B31A, 4'b0001, 480, 484);
        applyStimulus();
        waitStrobe(400, latency);
        checkOutput("s2_strobeLatency", 64'(latency), 64'd40);
        waitHalted("s2", 3000);
        finishScenario("s2", 8'd2);

        // A four-note chord, a five-note chord that overflows into voice 3,
        // then a single note that clears the upper voices.
        $display("[TB] scenario s3: chords");
        clearMem();
        mem[0]  = 16'hF31A;
        mem[1]  = 16'hF31B;
        mem[2]  = 16'hF31C;
        mem[3]  = 16'hB31D;
        mem[4]  = 16'hF311;
        mem[5]  = 16'hF312;
        mem[6]  = 16'hF313;
        mem[7]  = 16'hF314;
        mem[8]  = 16'hB315;
        mem[9]  = 16'hB316;
        mem[10] = 16'h0000;
        expectNote(31, 64'hB31D_F31C_F31B_F31A, 4'b1111, 960, 980);
        expectNote(32, 64'hB315_F313_F312_F311, 4'b1111, 960, 964);
        expectNote(33, 64'h0000_0000_0000_B316, 4'b0001, 960, 964);
        applyStimulus();
        waitHalted("s3", 6000);
        finishScenario("s3", 8'd10);

        // REP cnt=2 at level 0 plays the body three times; level 7 is beyond
        // the repeat depth and acts as a NOP.
        $display("[TB] scenario s4: repeats");
        clearMem();
        mem[0] = 16'hB01A;
        mem[1] = 16'h3010;
        mem[2] = 16'h3017;
        mem[3] = 16'h0000;
        expectNote(41, 64'h0000_0000_0000_B01A, 4'b0001, 120, 128);
        expectNote(42, 64'h0000_0000_0000_B01A, 4'b0001, 120, 128);
        expectNote(43, 64'h0000_0000_0000_B01A, 4'b0001, 120, 132);
        applyStimulus();
        waitHalted("s4", 2000);
        finishScenario("s4", 8'd3);

        // REP_HI supplies the upper target bits; a NOP precedes the jump to 64.
        $display("[TB] scenario s4b: repeat high bits");
        clearMem();
        mem[0]  = 16'h2001;
        mem[1]  = 16'h4000;
        mem[2]  = 16'h3009;
        mem[64] = 16'hB01A;
        mem[65] = 16'h3009;
        mem[66] = 16'h0000;
        expectNote(44, 64'h0000_0000_0000_B01A, 4'b0001, 120, 128);
        applyStimulus();
        waitHalted("s4b", 2000);
        finishScenario("s4b", 8'd66);

        // Styles: rest, staccato gap longer than the note, normal gap of 100.
        $display("[TB] scenario s5: styles");
        clearMem();
        mem[0] = 16'h831A;
        mem[1] = 16'h931A;
        mem[2] = 16'hA31A;
        mem[3] = 16'h0000;
        expectNote(51, 64'h0000_0000_0000_831A, 4'b0000, 0, 964);
        expectNote(52, 64'h0000_0000_0000_931A, 4'b0000, 0, 964);
        expectNote(53, 64'h0000_0000_0000_A31A, 4'b0001, 860, 964);
        applyStimulus();
        waitHalted("s5", 6000);
        finishScenario("s5", 8'd3);

        // PAUSE for 100 cycles mid-note: gates drop and the note ends 100 late.
        $display("[TB] scenario s6: pause");
        clearMem();
        mem[0] = 16'hB31A;
        mem[1] = 16'h0000;
        expectNote(6, 64'h0000_0000_0000_B31A, 4'b0001, 960, 1064);
        applyStimulus();
        waitStrobe(200, latency);
        repeat (200) @(negedge CLK);
        #2 PAUSE = 1'b1;
        #1 checkOutput("s6_pausedGate", 64'(VOICE_GATE), 64'd0);
        repeat (100) @(negedge CLK);
        #2 PAUSE = 1'b0;
        waitHalted("s6", 3000);
        finishScenario("s6", 8'd1);

        // Reset mid-note: outputs clear at once, then the song restarts from 0.
        $display("[TB] scenario s7: reset mid-note");
        clearMem();
        mem[0] = 16'hB31A;
        mem[1] = 16'h0000;
        expectNote(71, 64'h0000_0000_0000_B31A, 4'b0001, 960, 964);
        applyStimulus();
        waitStrobe(200, latency);
        repeat (300) @(negedge CLK);
        #3 RST_N = 1'b0;
        #1;
        checkOutput("s7_rst_PC", 64'(PC), 64'd0);
        checkOutput("s7_rst_MEM_A", 64'(MEM_A), 64'd0);
        checkOutput("s7_rst_VOICE_NOTE", VOICE_NOTE, 64'd0);
        checkOutput("s7_rst_VOICE_GATE", 64'(VOICE_GATE), 64'd0);
        checkOutput("s7_rst_NOTE_STROBE", 64'(NOTE_STROBE), 64'd0);
        checkOutput("s7_rst_HALTED", 64'(HALTED), 64'd0);
        expectNote(72, 64'h0000_0000_0000_B31A, 4'b0001, 960, 964);
        repeat (2) @(negedge CLK);
        #1 RST_N = 1'b1;
        waitStrobe(200, latency);
        checkOutput("s7_restartLatency", 64'(latency), 64'd4);
        waitHalted("s7", 3000);
        finishScenario("s7", 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
